// File: rtl/alu_pkg.sv
// Shared opcode map, FSM encoding and helpers for the execute-stage ALU.
package alu_pkg;

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_SRL   = 5'b00010;
  localparam logic [4:0] OP_AND   = 5'b00011;
  localparam logic [4:0] OP_SLL   = 5'b00100;
  localparam logic [4:0] OP_SLT   = 5'b00101;
  localparam logic [4:0] OP_OR    = 5'b00110;
  localparam logic [4:0] OP_SLLV  = 5'b01000;
  localparam logic [4:0] OP_SRLV  = 5'b01001;
  localparam logic [4:0] OP_SRAV  = 5'b01010;
  localparam logic [4:0] OP_ROTRV = 5'b01011;
  localparam logic [4:0] OP_NOR   = 5'b01101;
  localparam logic [4:0] OP_XOR   = 5'b01111;
  localparam logic [4:0] OP_MOVN  = 5'b10000;
  localparam logic [4:0] OP_MOVZ  = 5'b10001;
  localparam logic [4:0] OP_ROTR  = 5'b10010;
  localparam logic [4:0] OP_SRA   = 5'b10011;
  localparam logic [4:0] OP_SEB   = 5'b10100;
  localparam logic [4:0] OP_SLTU  = 5'b10110;
  localparam logic [4:0] OP_SEH   = 5'b10111;
  localparam logic [4:0] OP_MULT  = 5'b11000;
  localparam logic [4:0] OP_MULTU = 5'b11001;
  localparam logic [4:0] OP_MADD  = 5'b11010;
  localparam logic [4:0] OP_MSUB  = 5'b11011;
  localparam logic [4:0] OP_MFHI  = 5'b11100;
  localparam logic [4:0] OP_MFLO  = 5'b11101;
  localparam logic [4:0] OP_MTHI  = 5'b11110;
  localparam logic [4:0] OP_MTLO  = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_FIN  = 2'd2
  } alu_state_e;

  function automatic logic is_mul_op(input logic [4:0] op);
    return op[4:2] == 3'b110;
  endfunction

  // Shift by 32 yields 0, so a rotate by 0 collapses to v itself.
  function automatic logic [31:0] rotr32(input logic [31:0] v, input logic [4:0] sh);
    return (v >> sh) | (v << (6'd32 - {1'b0, sh}));
  endfunction

endpackage

// File: rtl/alu_exec_unit_mult_iter.sv
// Unsigned shift-add multiplier: one partial product per clock after start.
module mult_iter #(
  parameter int W     = 32,
  parameter int ITERS = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           done_o,
  output logic [2*W-1:0] prod_o
);

  localparam int CW = $clog2(ITERS);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  logic [2*W-1:0] mcand_q, mcand_d, acc_q, acc_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           run_q, run_d;

  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (start_i) begin
      mcand_d  = {{W{1'b0}}, a_i};
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == LAST) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

  // High during the final iteration; prod_o is complete on the next cycle.
  assign done_o = run_q && (cnt_q == LAST);
  assign prod_o = acc_q;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with HI/LO pair and an iterative multiplier that stalls via Busy.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              InValid,
  input  logic [4:0]        ALUOp2,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [4:0]        ShAmt,
  output logic              Busy,
  output logic              OutValid,
  output logic [DATA_W-1:0] Result,
  output logic              Zero,
  output logic              WriteOk,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO
);

  alu_state_e          state_q, state_d;
  logic [DATA_W-1:0]   res_q, res_d, hi_q, hi_d, lo_q, lo_d;
  logic                zero_q, zero_d, wok_q, wok_d, ov_q, ov_d;
  logic [4:0]          op_q, op_d;
  logic                neg_q, neg_d;

  logic [DATA_W-1:0]   sc_res;
  logic                sc_wok;
  logic                mul_start, mul_done, mul_signed;
  logic [DATA_W-1:0]   mag_a, mag_b;
  logic [2*DATA_W-1:0] prod, sprod, fin_val;

  always_comb begin
    sc_res = '0;
    sc_wok = 1'b1;
    case (ALUOp2)
      OP_ADD:   sc_res = A + B;
      OP_SUB:   sc_res = A - B;
      OP_AND:   sc_res = A & B;
      OP_OR:    sc_res = A | B;
      OP_NOR:   sc_res = ~(A | B);
      OP_XOR:   sc_res = A ^ B;
      OP_SLL:   sc_res = B << ShAmt;
      OP_SRL:   sc_res = B >> ShAmt;
      OP_SRA:   sc_res = $unsigned($signed(B) >>> ShAmt);
      OP_ROTR:  sc_res = rotr32(B, ShAmt);
      OP_SLLV:  sc_res = B << A[4:0];
      OP_SRLV:  sc_res = B >> A[4:0];
      OP_SRAV:  sc_res = $unsigned($signed(B) >>> A[4:0]);
      OP_ROTRV: sc_res = rotr32(B, A[4:0]);
      OP_SLT:   sc_res = {{(DATA_W-1){1'b0}}, $signed(A) < $signed(B)};
      OP_SLTU:  sc_res = {{(DATA_W-1){1'b0}}, A < B};
      OP_SEB:   sc_res = {{(DATA_W-8){B[7]}}, B[7:0]};
      OP_SEH:   sc_res = {{(DATA_W-16){B[15]}}, B[15:0]};
      OP_MOVN: begin sc_res = A; sc_wok = (B != '0); end
      OP_MOVZ: begin sc_res = A; sc_wok = (B == '0); end
      OP_MFHI:  sc_res = hi_q;
      OP_MFLO:  sc_res = lo_q;
      default:  sc_wok = 1'b0;  // MTHI/MTLO and unknown codes
    endcase
  end

  // Multiplier sees magnitudes; the sign is reapplied at FIN.
  assign mul_signed = (ALUOp2 != OP_MULTU);
  assign mag_a      = (mul_signed && A[DATA_W-1]) ? -A : A;
  assign mag_b      = (mul_signed && B[DATA_W-1]) ? -B : B;

  mult_iter #(.W(DATA_W), .ITERS(MUL_CYCLES)) u_mult (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .start_i (mul_start),
    .a_i     (mag_a),
    .b_i     (mag_b),
    .done_o  (mul_done),
    .prod_o  (prod)
  );

  always_comb begin
    sprod = neg_q ? -prod : prod;
    case (op_q)
      OP_MADD: fin_val = {hi_q, lo_q} + sprod;
      OP_MSUB: fin_val = {hi_q, lo_q} - sprod;
      default: fin_val = sprod;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    zero_d    = zero_q;
    wok_d     = wok_q;
    ov_d      = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    op_d      = op_q;
    neg_d     = neg_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: if (InValid) begin
        if (is_mul_op(ALUOp2)) begin
          mul_start = 1'b1;
          op_d      = ALUOp2;
          neg_d     = mul_signed && (A[DATA_W-1] ^ B[DATA_W-1]);
          state_d   = ST_MUL;
        end else begin
          res_d  = sc_res;
          zero_d = (sc_res == '0);
          wok_d  = sc_wok;
          ov_d   = 1'b1;
          if (ALUOp2 == OP_MTHI) hi_d = A;
          if (ALUOp2 == OP_MTLO) lo_d = A;
        end
      end
      ST_MUL: if (mul_done) state_d = ST_FIN;
      ST_FIN: begin
        {hi_d, lo_d} = fin_val;
        res_d   = '0;
        zero_d  = 1'b1;
        wok_d   = 1'b0;
        ov_d    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      zero_q  <= 1'b0;
      wok_q   <= 1'b0;
      ov_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      wok_q   <= wok_d;
      ov_q    <= ov_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
    end
  end

  assign Busy     = (state_q != ST_IDLE);
  assign OutValid = ov_q;
  assign Result   = res_q;
  assign Zero     = zero_q;
  assign WriteOk  = wok_q;
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed table plus multiply/reset sequences for alu_exec_unit.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset, InValid, Busy, OutValid, Zero, WriteOk;
  logic [4:0]  ALUOp2, ShAmt;
  logic [31:0] A, B, Result, HI, LO;

  int n_chk = 0;
  int n_fail = 0;

  alu_exec_unit #(.DATA_W(32), .MUL_CYCLES(32)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .ALUOp2(ALUOp2),
    .A(A), .B(B), .ShAmt(ShAmt), .Busy(Busy), .OutValid(OutValid),
    .Result(Result), .Zero(Zero), .WriteOk(WriteOk), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        wok;
    logic        chk_res;
  } vec_t;

  vec_t vt[26];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue a multiply, hold another op on the inputs for the whole stall,
  // then check completion and that the held op lands the cycle after.
  task automatic run_mul(input string nm, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic [4:0] hop, input logic [31:0] ha, input logic [31:0] hb,
                         input logic [31:0] eres);
    int   cyc;
    logic seen;
    InValid = 1'b1; ALUOp2 = op; A = a; B = b; ShAmt = 5'd0;
    tick();
    ALUOp2 = hop; A = ha; B = hb;
    cyc = 0; seen = 1'b0;
    while (Busy === 1'b1 && cyc < 100) begin
      cyc++;
      if (OutValid !== 1'b0) seen = 1'b1;
      tick();
    end
    chk({nm, " busy cycles"}, 64'(cyc), 64'd33);
    chk({nm, " no early OutValid"}, 64'(seen), 64'd0);
    chk({nm, " OutValid"}, 64'(OutValid), 64'd1);
    chk({nm, " WriteOk"}, 64'(WriteOk), 64'd0);
    chk({nm, " Result"}, 64'(Result), 64'd0);
    chk({nm, " HI"}, 64'(HI), 64'(ehi));
    chk({nm, " LO"}, 64'(LO), 64'(elo));
    tick();
    InValid = 1'b0;
    chk({nm, " held op OutValid"}, 64'(OutValid), 64'd1);
    chk({nm, " held op Result"}, 64'(Result), 64'(eres));
  endtask

  initial begin
    int   n;
    logic seen;

    vt[0]  = '{OP_ADD,   32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b1, 1'b1};
    vt[1]  = '{OP_SLT,   32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 1'b1, 1'b1};
    vt[2]  = '{OP_SLTU,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b1, 1'b1};
    vt[3]  = '{OP_SUB,   32'h00000005, 32'h00000007, 5'd0,  32'hFFFFFFFE, 1'b1, 1'b1};
    vt[4]  = '{OP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b1, 1'b1};
    vt[5]  = '{OP_OR,    32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hFFF0FFF0, 1'b1, 1'b1};
    vt[6]  = '{OP_NOR,   32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h000F000F, 1'b1, 1'b1};
    vt[7]  = '{OP_XOR,   32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h0FF00FF0, 1'b1, 1'b1};
    vt[8]  = '{OP_MOVZ,  32'h00001234, 32'h00000000, 5'd0,  32'h00001234, 1'b1, 1'b1};
    vt[9]  = '{OP_MOVN,  32'h00001234, 32'h00000000, 5'd0,  32'h00001234, 1'b0, 1'b1};
    vt[10] = '{OP_ROTR,  32'h00000000, 32'h80000001, 5'd1,  32'hC0000000, 1'b1, 1'b1};
    vt[11] = '{OP_ROTR,  32'h00000000, 32'h12345678, 5'd0,  32'h12345678, 1'b1, 1'b1};
    vt[12] = '{OP_SRAV,  32'h00000004, 32'h80000000, 5'd0,  32'hF8000000, 1'b1, 1'b1};
    vt[13] = '{OP_SEB,   32'h00000000, 32'h00000080, 5'd0,  32'hFFFFFF80, 1'b1, 1'b1};
    vt[14] = '{OP_SEH,   32'h00000000, 32'h00008001, 5'd0,  32'hFFFF8001, 1'b1, 1'b1};
    vt[15] = '{OP_SLL,   32'h00000000, 32'h00000001, 5'd31, 32'h80000000, 1'b1, 1'b1};
    vt[16] = '{OP_SRL,   32'h00000000, 32'h80000000, 5'd4,  32'h08000000, 1'b1, 1'b1};
    vt[17] = '{OP_SRA,   32'h00000000, 32'h80000000, 5'd0,  32'h80000000, 1'b1, 1'b1};
    vt[18] = '{OP_SLLV,  32'h00000023, 32'h00000001, 5'd0,  32'h00000008, 1'b1, 1'b1};
    vt[19] = '{OP_SRLV,  32'h00000001, 32'h000000F0, 5'd0,  32'h00000078, 1'b1, 1'b1};
    vt[20] = '{OP_ROTRV, 32'h00000004, 32'h0000000F, 5'd0,  32'hF0000000, 1'b1, 1'b1};
    vt[21] = '{5'b00111,  32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b0, 1'b1};
    vt[22] = '{OP_MTHI,  32'hDEADBEEF, 32'h00000000, 5'd0,  32'h00000000, 1'b0, 1'b0};
    vt[23] = '{OP_MFHI,  32'h00000000, 32'h00000000, 5'd0,  32'hDEADBEEF, 1'b1, 1'b1};
    vt[24] = '{OP_MTLO,  32'hCAFEF00D, 32'h00000000, 5'd0,  32'h00000000, 1'b0, 1'b0};
    vt[25] = '{OP_MFLO,  32'h00000000, 32'h00000000, 5'd0,  32'hCAFEF00D, 1'b1, 1'b1};

    Reset = 1'b1; InValid = 1'b0; ALUOp2 = '0; A = '0; B = '0; ShAmt = '0;
    tick(); tick();
    Reset = 1'b0;
    chk("reset Busy", 64'(Busy), 64'd0);
    chk("reset OutValid", 64'(OutValid), 64'd0);
    chk("reset Result", 64'(Result), 64'd0);
    chk("reset Zero", 64'(Zero), 64'd0);
    chk("reset WriteOk", 64'(WriteOk), 64'd0);
    chk("reset HI", 64'(HI), 64'd0);
    chk("reset LO", 64'(LO), 64'd0);

    // Back-to-back single-cycle ops, one accepted per clock.
    for (int i = 0; i < 26; i++) begin
      InValid = 1'b1; ALUOp2 = vt[i].op; A = vt[i].a; B = vt[i].b; ShAmt = vt[i].sh;
      tick();
      chk($sformatf("vec%0d OutValid", i), 64'(OutValid), 64'd1);
      chk($sformatf("vec%0d WriteOk", i), 64'(WriteOk), 64'(vt[i].wok));
      if (vt[i].chk_res) begin
        chk($sformatf("vec%0d Result", i), 64'(Result), 64'(vt[i].res));
        chk($sformatf("vec%0d Zero", i), 64'(Zero), 64'(vt[i].res == 32'h0));
      end
    end
    InValid = 1'b0;
    tick();
    chk("idle OutValid", 64'(OutValid), 64'd0);
    chk("idle Result hold", 64'(Result), 64'hCAFEF00D);
    chk("MTHI value", 64'(HI), 64'hDEADBEEF);
    chk("MTLO value", 64'(LO), 64'hCAFEF00D);

    run_mul("MULT -3*7", OP_MULT, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFEB,
            OP_ADD, 32'h1, 32'h1, 32'h2);
    run_mul("MADD 2*5", OP_MADD, 32'h2, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF5,
            OP_MFLO, 32'h0, 32'h0, 32'hFFFFFFF5);
    run_mul("MSUB 2*5", OP_MSUB, 32'h2, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFEB,
            OP_MFHI, 32'h0, 32'h0, 32'hFFFFFFFF);
    run_mul("MULT min*min", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,
            OP_MFHI, 32'h0, 32'h0, 32'h40000000);
    run_mul("MADD -1*-1", OP_MADD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h40000000, 32'h1,
            OP_MFLO, 32'h0, 32'h0, 32'h1);

    // Reset in the middle of a multiply aborts it cleanly.
    InValid = 1'b1; ALUOp2 = OP_MULTU; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
    tick();
    InValid = 1'b0;
    repeat (9) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("abort Busy", 64'(Busy), 64'd0);
    chk("abort OutValid", 64'(OutValid), 64'd0);
    chk("abort Result", 64'(Result), 64'd0);
    chk("abort HI", 64'(HI), 64'd0);
    chk("abort LO", 64'(LO), 64'd0);
    seen = 1'b0;
    n = 0;
    repeat (40) begin
      tick();
      n++;
      if (OutValid !== 1'b0 || Busy !== 1'b0) seen = 1'b1;
    end
    chk("abort stays quiet", 64'(seen), 64'd0);
    run_mul("MULTU max*max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001,
            OP_SUB, 32'h3, 32'h1, 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
